// File: rtl/x86_decq_pkg.sv
// Shared types and opcode tables for the x86 decode queue.
// Prefix folding is enabled by defining X86_DECQ_PREFIX_EN.
package x86_decq_pkg;

    typedef enum logic [1:0] {
        SEG_ES = 2'd0,
        SEG_CS = 2'd1,
        SEG_SS = 2'd2,
        SEG_DS = 2'd3
    } seg_e;

    typedef enum logic [1:0] {
        REP_NONE = 2'b00,
        REP_NE   = 2'b10,
        REP_E    = 2'b11
    } rep_e;

    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;

    typedef struct packed {
        logic [7:0]  op0;
        logic [7:0]  op1;
        logic [15:0] imm;
        logic [15:0] offset;
        logic [2:0]  len;
        logic        segOv;
        seg_e        seg;
        rep_e        rep;
        logic        lock;
        logic        inv;
    } dec_rec_t;

    function automatic logic isSegPfx(input logic [7:0] op);
        return op == PFX_ES || op == PFX_CS ||
               op == PFX_SS || op == PFX_DS;
    endfunction

    function automatic logic isPrefix(input logic [7:0] op);
        return isSegPfx(op) || op == PFX_LOCK ||
               op == PFX_REPNE || op == PFX_REP;
    endfunction

    function automatic logic isModrm(input logic [7:0] op);
        return (op[7:6] == 2'b00 && !op[2]) ||
               op[7:4] == 4'h8 ||
               op[7:2] == 6'b110001 ||
               op[7:2] == 6'b110100 ||
               op[7:3] == 5'b11011 ||
               op[7:1] == 7'b1111011 ||
               op[7:1] == 7'b1111111;
    endfunction

    function automatic logic isUndef(input logic [7:0] op);
        return op[7:4] == 4'h6 ||
               op[7:1] == 7'b1100000 ||
               op[7:1] == 7'b1100100 ||
               op == 8'hD6 || op == 8'hF1;
    endfunction

endpackage

// File: rtl/x86_decq_len.sv
// Combinational length, class and field extractor.
// Looks only at the first six bytes of the prefetch window.
module x86_decq_len
    import x86_decq_pkg::*;
#(
    parameter int WIN_BYTES = 6
) (
    input  logic [WIN_BYTES*8-1:0] window,
    output logic                   modrm,
    output logic [2:0]             len,
    output logic [7:0]             op1,
    output logic [15:0]            imm,
    output logic [15:0]            offset,
    output logic                   inv
);

    logic [7:0] b0, b1, b2, b3, b4, b5;
    logic [1:0] md;
    logic [2:0] rm, rg;
    logic [1:0] dispLen, dataLen;
    logic [7:0] lo, hi;
    logic       w;

    assign b0 = window[7:0];
    assign b1 = window[15:8];
    assign b2 = window[23:16];
    assign b3 = window[31:24];
    assign b4 = window[39:32];
    assign b5 = window[47:40];
    assign md = b1[7:6];
    assign rg = b1[5:3];
    assign rm = b1[2:0];

    assign modrm = isModrm(b0);
    assign inv   = isUndef(b0);
    assign op1   = modrm ? b1 : 8'hC0;

    always_comb begin
        dispLen = 2'd0;
        dataLen = 2'd0;
        lo      = b2;
        hi      = b3;
        w       = 1'b0;
        len     = 3'd1;
        imm     = 16'h0000;
        offset  = 16'h0000;
        if (modrm) begin
            unique case (md)
                2'b00:   dispLen = (rm == 3'b110) ? 2'd2 : 2'd0;
                2'b01:   dispLen = 2'd1;
                2'b10:   dispLen = 2'd2;
                default: dispLen = 2'd0;
            endcase
            unique case (1'b1)
                b0 == 8'h81, b0 == 8'hC7:
                    dataLen = 2'd2;
                b0 == 8'h80, b0 == 8'h83, b0 == 8'hC6:
                    dataLen = 2'd1;
                b0 == 8'hF6:
                    dataLen = (rg == 3'b000) ? 2'd1 : 2'd0;
                b0 == 8'hF7:
                    dataLen = (rg == 3'b000) ? 2'd2 : 2'd0;
                default:
                    dataLen = 2'd0;
            endcase
            // Immediate data follows the displacement bytes.
            unique case (dispLen)
                2'd0: begin lo = b2; hi = b3; end
                2'd1: begin lo = b3; hi = b4; end
                default: begin lo = b4; hi = b5; end
            endcase
            len = 3'd2 + {1'b0, dispLen} + {1'b0, dataLen};
            if (md == 2'b01)
                offset = {{8{b2[7]}}, b2};
            else if (dispLen == 2'd2)
                offset = {b3, b2};
            if (dataLen == 2'd2)
                imm = {hi, lo};
            else if (dataLen == 2'd1)
                imm = (b0 == 8'h83) ? {{8{lo[7]}}, lo} : {8'h00, lo};
        end else begin
            unique case (1'b1)
                (b0[7:6] == 2'b00 && b0[2:1] == 2'b10),
                b0[7:1] == 7'b1010100: begin
                    w   = b0[0];
                    len = w ? 3'd3 : 3'd2;
                    imm = w ? {b2, b1} : {8'h00, b1};
                end
                b0[7:4] == 4'hB: begin
                    w   = b0[3];
                    len = w ? 3'd3 : 3'd2;
                    imm = w ? {b2, b1} : {8'h00, b1};
                end
                b0[7:1] == 7'b1101010: begin
                    len    = 3'd2;
                    offset = {8'h00, b1};
                end
                b0 == 8'hCD, b0[7:2] == 6'b111001: begin
                    len = 3'd2;
                    imm = {8'h00, b1};
                end
                b0 == 8'hEB, b0[7:2] == 6'b111000,
                b0[7:4] == 4'h7: begin
                    len = 3'd2;
                    imm = {{8{b1[7]}}, b1};
                end
                b0[7:2] == 6'b101000: begin
                    len    = 3'd3;
                    offset = {b2, b1};
                end
                b0[7:1] == 7'b1110100, b0 == 8'hC2, b0 == 8'hCA: begin
                    len = 3'd3;
                    imm = {b2, b1};
                end
                b0 == 8'h9A, b0 == 8'hEA: begin
                    len    = 3'd5;
                    imm    = {b2, b1};
                    offset = {b4, b3};
                end
                b0 == 8'hCC: imm = 16'd3;
                b0 == 8'hCE: imm = 16'd4;
                default: len = 3'd1;
            endcase
        end
    end

endmodule

// File: rtl/x86_decode_queue.sv
// Length-decoding front end with prefix folding and output FIFO.
// Define X86_DECQ_PREFIX_EN to fold 8086 prefix bytes into records.
module x86_decode_queue
    import x86_decq_pkg::*;
#(
    parameter int WIN_BYTES = 6,
    parameter int DEPTH     = 2
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iJumped,
    input  logic [WIN_BYTES*8-1:0]       iBuf,
    input  logic [$clog2(WIN_BYTES+1)-1:0] iAvail,
    output logic                         oConsume,
    output logic [2:0]                   oUsed,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [7:0]                   oOp0,
    output logic [7:0]                   oOp1,
    output logic [15:0]                  oImm,
    output logic [15:0]                  oOffset,
    output logic [2:0]                   oLen,
    output logic                         oSegOv,
    output logic [1:0]                   oSeg,
    output logic [1:0]                   oRep,
    output logic                         oLock,
    output logic                         oInv
);

    localparam int AW = $clog2(WIN_BYTES + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic        modrm, inv;
    logic [2:0]  len;
    logic [7:0]  op0, op1;
    logic [15:0] imm, offset;

    x86_decq_len #(.WIN_BYTES(WIN_BYTES)) uLen (
        .window (iBuf),
        .modrm  (modrm),
        .len    (len),
        .op1    (op1),
        .imm    (imm),
        .offset (offset),
        .inv    (inv)
    );

    dec_rec_t       fifo [DEPTH];
    dec_rec_t       rec, head;
    logic [PW-1:0]  rdPtr, wrPtr, headIdx;
    logic [CW-1:0]  count;
    logic           pendSegOv, pendLock;
    seg_e           pendSeg;
    rep_e           pendRep;
    logic           isPfx, headValid, pop, space;
    logic           availOk, fire, push;

    assign op0 = iBuf[7:0];

`ifdef X86_DECQ_PREFIX_EN
    assign isPfx = isPrefix(op0);
`else
    assign isPfx = 1'b0;
`endif

    assign headValid = count != '0;
    assign pop       = headValid && iReady && !iJumped;
    assign space     = (count != CW'(DEPTH)) || pop;
    assign availOk   = (iAvail != '0) &&
                       (!modrm || iAvail >= AW'(2)) &&
                       (iAvail >= AW'(len));
    // oConsume high means the window has not shifted yet.
    assign fire      = !iJumped && !oConsume && availOk &&
                       (isPfx || space);
    assign push      = fire && !isPfx;

    always_comb begin
        rec        = '0;
        rec.op0    = op0;
        rec.op1    = op1;
        rec.imm    = imm;
        rec.offset = offset;
        rec.len    = len;
        rec.segOv  = pendSegOv;
        rec.seg    = pendSeg;
        rec.rep    = pendRep;
        rec.lock   = pendLock;
        rec.inv    = inv;
    end

    // An empty FIFO keeps showing the most recently popped record.
    assign headIdx = headValid ? rdPtr : rdPtr - 1'b1;
    assign head    = fifo[headIdx];

    assign oValid  = headValid;
    assign oOp0    = head.op0;
    assign oOp1    = head.op1;
    assign oImm    = head.imm;
    assign oOffset = head.offset;
    assign oLen    = head.len;
    assign oSegOv  = head.segOv;
    assign oSeg    = head.seg;
    assign oRep    = head.rep;
    assign oLock   = head.lock;
    assign oInv    = head.inv;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oConsume  <= 1'b0;
            oUsed     <= 3'd0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            pendSegOv <= 1'b0;
            pendSeg   <= SEG_ES;
            pendRep   <= REP_NONE;
            pendLock  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
        end else begin
            oConsume <= fire;
            if (fire)
                oUsed <= isPfx ? 3'd1 : len;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            if (iJumped) begin
                count     <= '0;
                wrPtr     <= rdPtr;
                pendSegOv <= 1'b0;
                pendSeg   <= SEG_ES;
                pendRep   <= REP_NONE;
                pendLock  <= 1'b0;
            end else begin
                if (push) begin
                    fifo[wrPtr] <= rec;
                    wrPtr       <= wrPtr + 1'b1;
                    pendSegOv   <= 1'b0;
                    pendSeg     <= SEG_ES;
                    pendRep     <= REP_NONE;
                    pendLock    <= 1'b0;
                end
`ifdef X86_DECQ_PREFIX_EN
                if (fire && isPfx) begin
                    if (isSegPfx(op0)) begin
                        pendSegOv <= 1'b1;
                        pendSeg   <= seg_e'(op0[4:3]);
                    end else if (op0 == PFX_LOCK) begin
                        pendLock <= 1'b1;
                    end else begin
                        pendRep <= rep_e'({1'b1, op0[0]});
                    end
                end
`endif
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_x86_decode_queue.sv
// Directed bench for x86_decode_queue (WIN_BYTES 6, DEPTH 2).
module tb_x86_decode_queue;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iJumped = 1'b0;
    logic        iReady = 1'b0;
    logic [47:0] iBuf = '0;
    logic [2:0]  iAvail = '0;
    logic        oConsume, oValid, oSegOv, oLock, oInv;
    logic [2:0]  oUsed, oLen;
    logic [7:0]  oOp0, oOp1;
    logic [15:0] oImm, oOffset;
    logic [1:0]  oSeg, oRep;

    int nAssert = 0;
    int nFail = 0;

    x86_decode_queue #(.WIN_BYTES(6), .DEPTH(2)) dut (
        .iClk(iClk), .iRst(iRst), .iJumped(iJumped),
        .iBuf(iBuf), .iAvail(iAvail),
        .oConsume(oConsume), .oUsed(oUsed),
        .oValid(oValid), .iReady(iReady),
        .oOp0(oOp0), .oOp1(oOp1), .oImm(oImm),
        .oOffset(oOffset), .oLen(oLen),
        .oSegOv(oSegOv), .oSeg(oSeg), .oRep(oRep),
        .oLock(oLock), .oInv(oInv)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic show(input logic [7:0] b0, b1, b2, b3, b4, b5,
                        input logic [2:0] a);
        iBuf   = {b5, b4, b3, b2, b1, b0};
        iAvail = a;
    endtask

    task automatic decodeOne(input logic [7:0] b0, b1, b2, b3, b4,
                             input logic [2:0] a);
        show(b0, b1, b2, b3, b4, 8'h00, a);
        tick();
        iAvail = 3'd0;
        chk("one_consume", oConsume, 1);
        chk("one_valid", oValid, 1);
    endtask

    task automatic popOne();
        iAvail = 3'd0;
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        iRst = 1'b0;
        chk("rst_valid", oValid, 0);
        chk("rst_consume", oConsume, 0);
        chk("rst_used", oUsed, 0);
        chk("rst_op0", oOp0, 0);
        chk("rst_imm", oImm, 0);

        show(8'h81, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56, 3'd6);
        tick();
        iAvail = 3'd0;
        chk("t1_consume", oConsume, 1);
        chk("t1_used", oUsed, 6);
        chk("t1_valid", oValid, 1);
        chk("t1_op0", oOp0, 8'h81);
        chk("t1_op1", oOp1, 8'h06);
        chk("t1_offset", oOffset, 16'h1234);
        chk("t1_imm", oImm, 16'h5678);
        chk("t1_len", oLen, 6);
        chk("t1_inv", oInv, 0);
        popOne();
        chk("t1_popvalid", oValid, 0);
        chk("t1_noconsume", oConsume, 0);
        chk("t1_hold", oOp0, 8'h81);

        show(8'h83, 8'hC0, 8'hFF, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        chk("t3_stall", oConsume, 0);
        chk("t3_stallvalid", oValid, 0);
        iAvail = 3'd3;
        tick();
        iAvail = 3'd0;
        chk("t3_consume", oConsume, 1);
        chk("t3_used", oUsed, 3);
        chk("t3_imm", oImm, 16'hFFFF);
        chk("t3_offset", oOffset, 16'h0000);
        chk("t3_len", oLen, 3);
        chk("t3_op1", oOp1, 8'hC0);
        popOne();

        show(8'hEB, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        chk("t4_c1", oConsume, 1);
        show(8'hEB, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        chk("t4_inhibit", oConsume, 0);
        tick();
        chk("t4_c2", oConsume, 1);
        show(8'hEB, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        tick();
        chk("t4_full", oConsume, 0);
        chk("t4_valid", oValid, 1);
        chk("t4_imm0", oImm, 16'h0005);
        chk("t4_len", oLen, 2);
        chk("t4_op0", oOp0, 8'hEB);
        iReady = 1'b1;
        tick();
        chk("t4_poppush", oConsume, 1);
        chk("t4_imm1", oImm, 16'h0006);
        show(8'hEB, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        chk("t4_imm2", oImm, 16'h0007);
        chk("t4_inhibit2", oConsume, 0);
        tick();
        chk("t4_c4", oConsume, 1);
        chk("t4_imm3", oImm, 16'hFFF0);
        iAvail = 3'd0;
        tick();
        chk("t4_empty", oValid, 0);
        iReady = 1'b0;

        show(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        tick();
        tick();
        tick();
        iAvail = 3'd0;
        tick();
        chk("t5_full", oValid, 1);
`ifdef X86_DECQ_PREFIX_EN
        show(8'h26, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        tick();
        iAvail = 3'd0;
        chk("t5_pfx_consume", oConsume, 1);
        chk("t5_pfx_used", oUsed, 1);
        tick();
`endif
        iJumped = 1'b1;
        iReady = 1'b1;
        show(8'hEB, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        iJumped = 1'b0;
        iReady = 1'b0;
        chk("t5_flushed", oValid, 0);
        chk("t5_noconsume", oConsume, 0);
        tick();
        iAvail = 3'd0;
        chk("t5_after", oValid, 1);
        chk("t5_segov", oSegOv, 0);
        chk("t5_op0", oOp0, 8'hEB);
        popOne();

`ifdef X86_DECQ_PREFIX_EN
        show(8'h2E, 8'hF3, 8'hA4, 8'h00, 8'h00, 8'h00, 3'd3);
        tick();
        chk("t2_c1", oConsume, 1);
        chk("t2_u1", oUsed, 1);
        chk("t2_novalid", oValid, 0);
        show(8'hF3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        tick();
        chk("t2_c2", oConsume, 1);
        chk("t2_novalid2", oValid, 0);
        show(8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        tick();
        tick();
        iAvail = 3'd0;
        chk("t2_valid", oValid, 1);
        chk("t2_op0", oOp0, 8'hA4);
        chk("t2_segov", oSegOv, 1);
        chk("t2_seg", oSeg, 1);
        chk("t2_rep", oRep, 2'b11);
        chk("t2_lock", oLock, 0);
        chk("t2_len", oLen, 1);
        popOne();
`else
        show(8'hF0, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2);
        tick();
        chk("t6_c1", oConsume, 1);
        chk("t6_u1", oUsed, 1);
        chk("t6_op0", oOp0, 8'hF0);
        chk("t6_lock", oLock, 0);
        show(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        tick();
        tick();
        chk("t6_c2", oConsume, 1);
        iAvail = 3'd0;
        iReady = 1'b1;
        tick();
        chk("t6_op0b", oOp0, 8'h90);
        chk("t6_validb", oValid, 1);
        chk("t6_lockb", oLock, 0);
        tick();
        iReady = 1'b0;
        chk("t6_empty", oValid, 0);
`endif

        decodeOne(8'h8B, 8'h46, 8'hFC, 8'h00, 8'h00, 3'd3);
        chk("f_mod01_len", oLen, 3);
        chk("f_mod01_off", oOffset, 16'hFFFC);
        chk("f_mod01_op1", oOp1, 8'h46);
        chk("f_mod01_imm", oImm, 0);
        popOne();
        decodeOne(8'hA1, 8'h34, 8'h12, 8'h00, 8'h00, 3'd3);
        chk("f_moffs_off", oOffset, 16'h1234);
        chk("f_moffs_imm", oImm, 0);
        popOne();
        decodeOne(8'h9A, 8'h11, 8'h22, 8'h33, 8'h44, 3'd5);
        chk("f_far_imm", oImm, 16'h2211);
        chk("f_far_off", oOffset, 16'h4433);
        chk("f_far_len", oLen, 5);
        popOne();
        decodeOne(8'hD4, 8'h0A, 8'h00, 8'h00, 8'h00, 3'd2);
        chk("f_aam_off", oOffset, 16'h000A);
        chk("f_aam_imm", oImm, 0);
        chk("f_aam_len", oLen, 2);
        popOne();
        decodeOne(8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        chk("f_int3", oImm, 3);
        popOne();
        decodeOne(8'hCE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        chk("f_into", oImm, 4);
        popOne();
        decodeOne(8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1);
        chk("f_inv", oInv, 1);
        chk("f_inv_len", oLen, 1);
        popOne();
        decodeOne(8'hB8, 8'h34, 8'h12, 8'h00, 8'h00, 3'd3);
        chk("f_movw_imm", oImm, 16'h1234);
        chk("f_movw_len", oLen, 3);
        popOne();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
